// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - butterfly issue / write-back handshake bundle
interface fft_stage_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int TW_W   = 7
);
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [TW_W-1:0]   tw_idx;
    logic              wb_valid;

    modport master (
        output issue_valid, addr_a, addr_b, tw_idx,
        input  issue_ready, wb_valid
    );

    modport slave (
        input  issue_valid, addr_a, addr_b, tw_idx,
        output issue_ready, wb_valid
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - schedules an in-place radix-2 DIT FFT onto one shared butterfly
module fft_stage_sequencer #(
    parameter int N      = 256,
    parameter int LOG2N  = 8,
    parameter int ADDR_W = 8,
    parameter int TW_W   = 7,
    parameter int STG_W  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    fft_stage_sequencer_if.master bus,
    output logic [STG_W-1:0]      o_stage,
    output logic                  o_bank_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_NEXT, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N / 2 - 1);
    localparam logic [STG_W-1:0]  LAST_STG = STG_W'(LOG2N - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_k;
    logic [ADDR_W-1:0]   r_out;
    logic [STG_W-1:0]    r_stage;
    logic                r_bank;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic [TW_W-1:0]     r_tw;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_k_nxt;
    logic [ADDR_W-1:0]   w_out_nxt;
    logic [STG_W-1:0]    w_stage_nxt;
    logic                w_bank_nxt;
    logic                w_valid_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_clr_out;
    logic                w_retire;
    logic [ADDR_W-1:0]   w_half;
    logic [ADDR_W-1:0]   w_j;
    logic [ADDR_W-1:0]   w_g;
    logic [ADDR_W-1:0]   w_gs;
    logic [ADDR_W-1:0]   w_a;
    logic [ADDR_W-1:0]   w_b;
    logic [TW_W-1:0]     w_tw;

    assign w_retire = r_valid & bus.issue_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        w_bank_nxt  = r_bank;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_clr_out   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ISSUE;
                    w_k_nxt     = '0;
                    w_stage_nxt = '0;
                    w_bank_nxt  = 1'b0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_clr_out   = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_retire) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = S_DRAIN;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_out == '0) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_stage == LAST_STG) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_ISSUE;
                    w_stage_nxt = r_stage + 1'b1;
                    w_bank_nxt  = ~r_bank;
                    w_k_nxt     = '0;
                    w_valid_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A write-back with nothing in flight is a protocol error; the counter never underflows.
    always_comb begin
        w_out_nxt = r_out;
        w_err_nxt = r_err;
        if (!w_retire && bus.wb_valid && (r_out == '0)) begin
            w_err_nxt = 1'b1;
        end
        if (w_clr_out) begin
            w_out_nxt = '0;
        end else if (w_retire && !bus.wb_valid) begin
            w_out_nxt = r_out + 1'b1;
        end else if (!w_retire && bus.wb_valid && (r_out != '0)) begin
            w_out_nxt = r_out - 1'b1;
        end
    end

    // Operand addresses are derived from the next k/stage so they land registered with issue_valid.
    always_comb begin
        w_half = ADDR_W'(1) << w_stage_nxt;
        w_j    = w_k_nxt & (w_half - 1'b1);
        w_g    = w_k_nxt >> w_stage_nxt;
        w_gs   = w_g << w_stage_nxt;
        w_a    = ADDR_W'({w_gs, 1'b0}) | w_j;
        w_b    = w_a | w_half;
        w_tw   = TW_W'(w_j << (LAST_STG - w_stage_nxt));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_out    <= '0;
            r_stage  <= '0;
            r_bank   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_k      <= w_k_nxt;
            r_out    <= w_out_nxt;
            r_stage  <= w_stage_nxt;
            r_bank   <= w_bank_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            if (w_valid_nxt) begin
                r_addr_a <= w_a;
                r_addr_b <= w_b;
                r_tw     <= w_tw;
            end
        end
    end

    assign bus.issue_valid = r_valid;
    assign bus.addr_a      = r_addr_a;
    assign bus.addr_b      = r_addr_b;
    assign bus.tw_idx      = r_tw;
    assign o_stage         = r_stage;
    assign o_bank_sel      = r_bank;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Controller that schedules a complete in-place radix-2 DIT FFT of N points onto one shared butterfly unit. For each stage it generates butterfly operand addresses, twiddle index and ping-pong bank select, and issues operations under a valid/ready handshake. It waits for all write-backs of a stage before advancing, and pulses `done` after the last stage. It sits between the frame buffer/twiddle ROMs and the butterfly in the MFCC `frame_fft_block`.

## Interface
- `N`, 256, FFT size (power of two, 8..1024)
- `LOG2N`, 8, log2(N); number of stages
- `ADDR_W`, 8, buffer address width (= LOG2N)
- `TW_W`, 7, twiddle index width (= LOG2N-1)
- `STG_W`, 3, stage counter width (≥ clog2(LOG2N))

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one FFT; sampled only in IDLE
- `issue_valid`  out  1  operation on `addr_a/addr_b/tw_idx` is valid
- `issue_ready`  in  1  butterfly accepts operation
- `addr_a`  out  ADDR_W  upper-leg buffer address
- `addr_b`  out  ADDR_W  lower-leg buffer address
- `tw_idx`  out  TW_W  twiddle ROM index
- `stage`  out  STG_W  current stage, 0..LOG2N-1
- `bank_sel`  out  1  read bank; write bank is `~bank_sel`
- `wb_valid`  in  1  butterfly completed one write-back
- `busy`  out  1  high from start acceptance until done
- `done`  out  1  one-cycle pulse, FFT complete
- `err`  out  1  sticky: write-back received with none outstanding

## Operation
- States: IDLE, ISSUE, DRAIN, NEXT, DONE.
- IDLE: `start`=1 → ISSUE; clears k, outstanding, stage=0, bank_sel=0; `busy`←1.
- ISSUE: for k = 0..N/2-1, with half = 2^stage, j = k & (half-1), g = k >> stage:
  - `addr_a` = g·2·half + j; `addr_b` = `addr_a` + half; `tw_idx` = j << (LOG2N-1-stage).
  - Operation retires when `issue_valid && issue_ready`; k increments, outstanding +1.
  - Outputs held stable while `issue_valid && !issue_ready`.
  - Retiring k = N/2-1 → DRAIN; `issue_valid` drops next cycle.
- DRAIN: wait until outstanding = 0, then → NEXT.
- NEXT (1 cycle): stage = LOG2N-1 → DONE; else stage+1, bank_sel toggles, k←0 → ISSUE.
- DONE (1 cycle): `done`=1, `busy`←0 → IDLE. Final data sits in bank `~bank_sel`.
- Outstanding counter: +1 on retire, −1 on `wb_valid`; both in the same cycle → unchanged. Width ADDR_W bits (max N/2).
- `wb_valid` with outstanding = 0 and no simultaneous retire: counter stays 0, `err`←1; cleared only by reset.
- `start` while busy: ignored.

## Timing
- Reset values: `issue_valid`=0, `addr_a`=0, `addr_b`=0, `tw_idx`=0, `stage`=0, `bank_sel`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- All outputs registered.
- `start` at cycle t → `busy`=1 and `issue_valid`=1 with k=0 at t+1.
- With `issue_ready` tied high: one issue per cycle, N/2 consecutive cycles per stage.
- Per-stage overhead: ≥1 DRAIN cycle + 1 NEXT cycle. Zero-latency write-back gives N/2+2 cycles per stage.
- `done` asserted in the cycle after the final NEXT.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). No pending operation survives.

## Test plan
- Reset: hold `reset`=0 with random inputs → all outputs at reset values; `start` ignored.
- N=8, `issue_ready`=1, `wb_valid` one cycle after each issue. Required issue sequence (a,b,tw):
  - stage0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - stage1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - stage2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - `bank_sel` reads 0,1,0 across stages; exactly one `done` pulse.
- Backpressure: N=8, `issue_ready` toggling 1,0,0,1… → sequence identical to the previous case; outputs stable during stalls; 12 total retires.
- Drain: withhold `wb_valid` after stage0's 4th issue for 10 cycles → state stays DRAIN and `stage` stays 0; release → stage becomes 1.
- Reset mid-FFT: assert `reset` during stage1 → outputs cleared. New `start` after release restarts at stage0, k=0.
- Misuse: `start` pulsed while busy → no restart. `wb_valid` in IDLE → `err`=1 and stays 1 until reset.
